// File: rtl/fetch_unit_pkg.sv
// Shared widths, opcodes and state encoding for the Risky fetch stage.
package fetch_unit_pkg;

   localparam int ADDRESS_SIZE     = 8;
   localparam int INSTRUCTION_SIZE = 16;
   localparam int OPCODE_MSB       = 15;
   localparam int OPCODE_LSB       = 12;

   typedef logic [ADDRESS_SIZE-1:0]          addr_t;
   typedef logic [INSTRUCTION_SIZE-1:0]      instr_t;
   typedef logic [OPCODE_MSB-OPCODE_LSB:0]   opcode_t;

   localparam opcode_t NOP  = 4'h0;
   localparam opcode_t HALT = 4'hF;

   localparam instr_t NOP_INSTRUCTION = {NOP, 12'h000};

   typedef enum logic {
      FETCH_RUN    = 1'b0,
      FETCH_HALTED = 1'b1
   } fetch_state_e;

   function automatic opcode_t opcode_of(instr_t word);
      return word[OPCODE_MSB:OPCODE_LSB];
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Control, instruction-memory and pipeline-register signals of the fetch stage.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic   stall;
   logic   jump;
   addr_t  jump_address;
   instr_t imem_data;
   logic   imem_request;
   addr_t  imem_address;
   instr_t instruction;
   addr_t  pc;
   logic   halted;

   modport master (
      input  stall, jump, jump_address, imem_data,
      output imem_request, imem_address, instruction, pc, halted
   );

   modport slave (
      output stall, jump, jump_address, imem_data,
      input  imem_request, imem_address, instruction, pc, halted
   );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for a word that returns while the pipeline is stalled.
module fetch_skid_buffer
   import fetch_unit_pkg::*;
(
   input  logic   clock,
   input  logic   reset,
   input  logic   flush,
   input  logic   write,
   input  logic   read,
   input  instr_t write_instruction,
   input  addr_t  write_pc,
   output logic   valid,
   output instr_t instruction,
   output addr_t  pc
);

   logic   valid_d, valid_q;
   instr_t instruction_d, instruction_q;
   addr_t  pc_d, pc_q;

   // flush wins over write; write and read never coincide (stall vs. no stall)
   always_comb begin
      valid_d       = valid_q;
      instruction_d = instruction_q;
      pc_d          = pc_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (write) begin
         valid_d       = 1'b1;
         instruction_d = write_instruction;
         pc_d          = write_pc;
      end else if (read) begin
         valid_d = 1'b0;
      end
   end

   // entry storage
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q       <= 1'b0;
         instruction_q <= NOP_INSTRUCTION;
         pc_q          <= '0;
      end else begin
         valid_q       <= valid_d;
         instruction_q <= instruction_d;
         pc_q          <= pc_d;
      end
   end

   assign valid       = valid_q;
   assign instruction = instruction_q;
   assign pc          = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues 1-cycle-latency memory reads and
// registers each returned word with its address for the read stage.
//
// state        | meaning
// FETCH_RUN    | issuing reads, accepting returned words
// FETCH_HALTED | HALT seen; no issue, returns discarded, skid drains
module fetch_unit
   import fetch_unit_pkg::*;
(
   input logic          clock,
   input logic          reset,
   fetch_unit_if.master bus
);

   fetch_state_e state_d, state_q;
   addr_t        fetch_pc_d, fetch_pc_q;
   logic         inflight_valid_d, inflight_valid_q;
   addr_t        inflight_pc_d, inflight_pc_q;
   instr_t       instruction_d, instruction_q;
   addr_t        pc_d, pc_q;

   logic   running, issue, returning, halt_seen;
   logic   skid_valid, skid_write, skid_read, skid_flush;
   instr_t skid_instruction;
   addr_t  skid_pc;

   fetch_skid_buffer u_skid (
      .clock             (clock),
      .reset             (reset),
      .flush             (skid_flush),
      .write             (skid_write),
      .read              (skid_read),
      .write_instruction (bus.imem_data),
      .write_pc          (inflight_pc_q),
      .valid             (skid_valid),
      .instruction       (skid_instruction),
      .pc                (skid_pc)
   );

   // issue decision, return routing, jump redirect and halt detection
   always_comb begin
      running   = (state_q == FETCH_RUN);
      issue     = running && !bus.jump && !skid_valid && !(bus.stall && inflight_valid_q);
      returning = inflight_valid_q && running;
      halt_seen = returning && (opcode_of(bus.imem_data) == HALT);

      state_d          = state_q;
      fetch_pc_d       = fetch_pc_q;
      inflight_valid_d = issue;
      inflight_pc_d    = inflight_pc_q;
      instruction_d    = instruction_q;
      pc_d             = pc_q;
      skid_write       = 1'b0;
      skid_read        = 1'b0;
      skid_flush       = 1'b0;

      if (issue) begin
         inflight_pc_d = fetch_pc_q;
         fetch_pc_d    = fetch_pc_q + addr_t'(1);
      end

      if (bus.jump) begin
         fetch_pc_d    = bus.jump_address;
         skid_flush    = 1'b1;
         instruction_d = NOP_INSTRUCTION;
         pc_d          = '0;
         state_d       = FETCH_RUN;
      end else begin
         if (!bus.stall) begin
            if (skid_valid) begin
               instruction_d = skid_instruction;
               pc_d          = skid_pc;
               skid_read     = 1'b1;
            end else if (returning) begin
               instruction_d = bus.imem_data;
               pc_d          = inflight_pc_q;
            end else begin
               instruction_d = NOP_INSTRUCTION;
               pc_d          = '0;
            end
         end else if (returning) begin
            skid_write = 1'b1;
         end
         if (halt_seen) begin
            state_d = FETCH_HALTED;
         end
      end
   end

   // pipeline, PC and state registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q          <= FETCH_RUN;
         fetch_pc_q       <= '0;
         inflight_valid_q <= 1'b0;
         inflight_pc_q    <= '0;
         instruction_q    <= NOP_INSTRUCTION;
         pc_q             <= '0;
      end else begin
         state_q          <= state_d;
         fetch_pc_q       <= fetch_pc_d;
         inflight_valid_q <= inflight_valid_d;
         inflight_pc_q    <= inflight_pc_d;
         instruction_q    <= instruction_d;
         pc_q             <= pc_d;
      end
   end

   assign bus.imem_request = issue;
   assign bus.imem_address = fetch_pc_q;
   assign bus.instruction  = instruction_q;
   assign bus.pc           = pc_q;
   assign bus.halted       = (state_q == FETCH_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stall/jump traffic,
// checked every cycle against a queue-based model of the fetch stream.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b0;
   bit   cmp_en = 1'b0;

   fetch_unit_if bus();

   fetch_unit dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   bit halt_map [256];

   // memory contents: the address itself, or a HALT word carrying the address
   function automatic instr_t mem_word(addr_t a);
      if (halt_map[a]) return {HALT, 4'h0, a};
      return {8'h00, a};
   endfunction

   // synchronous instruction memory, garbage when not requested
   always @(posedge clock) begin
      if (bus.imem_request) bus.imem_data <= mem_word(bus.imem_address);
      else                  bus.imem_data <= instr_t'($urandom);
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: addresses requested last cycle, addresses parked during stall,
   // and what the output register currently shows
   addr_t m_fetch = '0;
   addr_t m_pend[$];
   addr_t m_skid[$];
   bit    m_out_valid = 1'b0;
   addr_t m_out_addr = '0;
   bit    m_halted = 1'b0;
   bit    m_req, m_got;
   addr_t m_ret;

   function automatic bit exp_req();
      return !m_halted && !bus.jump && (m_skid.size() == 0) && !(bus.stall && (m_pend.size() > 0));
   endfunction

   function automatic instr_t exp_instr();
      return m_out_valid ? mem_word(m_out_addr) : NOP_INSTRUCTION;
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_fetch = '0;
         m_pend.delete();
         m_skid.delete();
         m_out_valid = 1'b0;
         m_out_addr = '0;
         m_halted = 1'b0;
      end else begin
         m_req = exp_req();
         m_got = 1'b0;
         m_ret = '0;
         if (bus.jump) begin
            m_fetch = bus.jump_address;
            m_pend.delete();
            m_skid.delete();
            m_out_valid = 1'b0;
            m_halted = 1'b0;
         end else begin
            if (m_pend.size() > 0 && !m_halted) begin
               m_ret = m_pend[0];
               m_got = 1'b1;
            end
            m_pend.delete();
            if (!bus.stall) begin
               if (m_skid.size() > 0) begin
                  m_out_addr = m_skid.pop_front();
                  m_out_valid = 1'b1;
               end else if (m_got) begin
                  m_out_addr = m_ret;
                  m_out_valid = 1'b1;
               end else begin
                  m_out_valid = 1'b0;
               end
            end else if (m_got) begin
               m_skid.push_back(m_ret);
            end
            if (m_got && halt_map[m_ret]) m_halted = 1'b1;
            if (m_req) begin
               m_pend.push_back(m_fetch);
               m_fetch = addr_t'(m_fetch + 1);
            end
         end
      end
   end

   // per-cycle comparison, mid-cycle
   always @(negedge clock) begin
      if (cmp_en && reset) begin
         chk("instruction", 32'(bus.instruction), 32'(exp_instr()));
         chk("pc", 32'(bus.pc), 32'(m_out_valid ? m_out_addr : addr_t'(0)));
         chk("halted", 32'(bus.halted), 32'(m_halted));
         chk("imem_request", 32'(bus.imem_request), 32'(exp_req()));
         chk("imem_address", 32'(bus.imem_address), 32'(m_fetch));
         chk("skid_inflight_excl", 32'(dut.skid_valid & dut.inflight_valid_q), 0);
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   initial begin
      bus.stall = 1'b0;
      bus.jump = 1'b0;
      bus.jump_address = '0;
      halt_map[8'h43] = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      cmp_en = 1'b1;

      // cycle 0: reset values
      chk("rst_instruction", 32'(bus.instruction), 32'(NOP_INSTRUCTION));
      chk("rst_pc", 32'(bus.pc), 0);
      chk("rst_halted", 32'(bus.halted), 0);
      chk("rst_imem_request", 32'(bus.imem_request), 1);
      chk("rst_imem_address", 32'(bus.imem_address), 0);
      cyc();
      chk("c1_instruction", 32'(bus.instruction), 32'(NOP_INSTRUCTION));
      chk("c1_imem_address", 32'(bus.imem_address), 1);
      cyc();
      chk("c2_instruction", 32'(bus.instruction), 32'h0000);
      chk("c2_pc", 32'(bus.pc), 0);
      cyc();
      chk("c3_pc", 32'(bus.pc), 1);
      repeat (4) cyc();
      chk("c7_instruction", 32'(bus.instruction), 32'h0005);

      // stall for 3 cycles while showing 5
      bus.stall = 1'b1;
      #1 chk("stall_req_c7", 32'(bus.imem_request), 0);
      cyc();
      chk("stall_c8_instruction", 32'(bus.instruction), 32'h0005);
      chk("stall_c8_req", 32'(bus.imem_request), 0);
      cyc();
      chk("stall_c9_instruction", 32'(bus.instruction), 32'h0005);
      cyc();
      bus.stall = 1'b0;
      chk("stall_c10_instruction", 32'(bus.instruction), 32'h0005);
      cyc();
      chk("release_skid_word", 32'(bus.instruction), 32'h0006);
      repeat (2) cyc();
      chk("release_next_7", 32'(bus.pc), 32'h07);
      cyc();
      chk("release_next_8", 32'(bus.pc), 32'h08);

      // fill the skid, then jump to 0x40 while still stalled
      bus.stall = 1'b1;
      repeat (2) cyc();
      bus.jump = 1'b1;
      bus.jump_address = 8'h40;
      #1 chk("jump_no_issue", 32'(bus.imem_request), 0);
      cyc();
      bus.stall = 1'b0;
      bus.jump = 1'b0;
      chk("jump_bubble1", 32'(bus.instruction), 32'(NOP_INSTRUCTION));
      chk("jump_target_issue", 32'(bus.imem_address), 32'h40);
      cyc();
      chk("jump_bubble2", 32'(bus.instruction), 32'(NOP_INSTRUCTION));
      cyc();
      chk("jump_target_pc", 32'(bus.pc), 32'h40);
      cyc();
      chk("jump_target_next", 32'(bus.pc), 32'h41);

      // HALT word sits at 0x43
      repeat (2) cyc();
      chk("halt_word", 32'(bus.instruction), 32'hF043);
      chk("halt_flag", 32'(bus.halted), 1);
      chk("halt_no_req", 32'(bus.imem_request), 0);
      repeat (4) cyc();
      chk("halt_bubble", 32'(bus.instruction), 32'(NOP_INSTRUCTION));
      bus.jump = 1'b1;
      bus.jump_address = 8'h10;
      cyc();
      bus.jump = 1'b0;
      chk("unhalt_flag", 32'(bus.halted), 0);
      chk("unhalt_addr", 32'(bus.imem_address), 32'h10);
      repeat (2) cyc();
      chk("unhalt_pc", 32'(bus.pc), 32'h10);

      // wrap-around past the top address
      bus.jump = 1'b1;
      bus.jump_address = 8'hFF;
      cyc();
      bus.jump = 1'b0;
      repeat (2) cyc();
      chk("wrap_top", 32'(bus.pc), 32'hFF);
      cyc();
      chk("wrap_zero", 32'(bus.pc), 0);
      cyc();
      chk("wrap_one", 32'(bus.pc), 1);

      // asynchronous reset with a word parked in the skid
      bus.stall = 1'b1;
      repeat (2) cyc();
      reset = 1'b0;
      #1;
      chk("arst_instruction", 32'(bus.instruction), 32'(NOP_INSTRUCTION));
      chk("arst_pc", 32'(bus.pc), 0);
      chk("arst_addr", 32'(bus.imem_address), 0);
      bus.stall = 1'b0;
      for (int i = 0; i < 256; i++) halt_map[i] = ($urandom_range(15) == 0);
      cyc();
      reset = 1'b1;
      chk("post_rst_instruction", 32'(bus.instruction), 32'(NOP_INSTRUCTION));
      chk("post_rst_pc", 32'(bus.pc), 0);
      chk("post_rst_addr", 32'(bus.imem_address), 0);
      chk("post_rst_halted", 32'(bus.halted), 0);

      // random stall/jump traffic
      for (int n = 0; n < 3000; n++) begin
         cyc();
         bus.stall = ($urandom_range(9) < 3);
         bus.jump = ($urandom_range(19) == 0);
         bus.jump_address = addr_t'($urandom);
      end
      bus.stall = 1'b0;
      bus.jump = 1'b0;
      repeat (2) cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
